// File: rtl/peripheral_wb_pkg.sv
// Shared definitions for the UART transmitter: FSM encodings, line control
// register bit positions and small frame-format helpers.
package peripheral_wb_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SEND_START  = 3'd1,
        S_SEND_BYTE   = 3'd2,
        S_SEND_PARITY = 3'd3,
        S_SEND_STOP   = 3'd4,
        S_POP_BYTE    = 3'd5
    } tx_state_e;

    // Bit positions inside lcr; LCR_BITS is the low index of the 2-bit length field.
    localparam int LCR_BITS = 0;
    localparam int LCR_SB   = 2;
    localparam int LCR_PE   = 3;
    localparam int LCR_EP   = 4;
    localparam int LCR_SP   = 5;
    localparam int LCR_BC   = 6;

    localparam logic [4:0] BIT_TICKS_M1 = 5'd15;

    // Number of data bits minus one: 00 -> 4 (5 bits) ... 11 -> 7 (8 bits).
    function automatic logic [2:0] data_bits_m1(input logic [1:0] bits);
        return {1'b1, bits};
    endfunction

    // Stop duration in 16x ticks minus one: 1, 1.5 or 2 stop bits.
    function automatic logic [4:0] stop_ticks_m1(input logic sb, input logic [1:0] bits);
        if (!sb) begin
            return 5'd15;
        end else if (bits == 2'b00) begin
            return 5'd23;
        end
        return 5'd31;
    endfunction

    // acc is the XOR of the data bits actually sent.
    function automatic logic parity_bit(input logic sp, input logic ep, input logic acc);
        if (sp) begin
            return ~ep;
        end
        return ep ? acc : ~acc;
    endfunction

endpackage

// File: rtl/peripheral_raminfr_wb.sv
// Inferred dual-port storage: synchronous write port, asynchronous read port.
module peripheral_raminfr_wb #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage carries no reset; occupancy is tracked by the FIFO pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/peripheral_uart_tfifo_wb.sv
// Transmit FIFO: wrapping pointers over inferred RAM, occupancy count,
// synchronous flush. Writes into a full FIFO are dropped unless a pop
// happens in the same cycle; pops from an empty FIFO are ignored.
module peripheral_uart_tfifo_wb
    import peripheral_wb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] top_q, top_d;
    logic [PTR_W-1:0] bottom_q, bottom_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok, push_ok, we;

    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != FULL_CNT) || pop_ok);
    assign we      = push_ok && !flush;

    always_comb begin
        top_d    = top_q;
        bottom_d = bottom_q;
        count_d  = count_q;
        if (flush) begin
            top_d    = '0;
            bottom_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                top_d = (top_q == LAST_PTR) ? '0 : top_q + 1'b1;
            end
            if (pop_ok) begin
                bottom_d = (bottom_q == LAST_PTR) ? '0 : bottom_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q    <= '0;
            bottom_q <= '0;
            count_q  <= '0;
        end else begin
            top_q    <= top_d;
            bottom_q <= bottom_d;
            count_q  <= count_d;
        end
    end

    peripheral_raminfr_wb #(
        .ADDR_W (PTR_W),
        .DATA_W (WIDTH),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (top_q),
        .raddr (bottom_q),
        .wdata (data_in),
        .rdata (data_out)
    );

    assign count = count_q;

endmodule

// File: rtl/peripheral_uart_transmitter_wb.sv
// UART transmitter: FIFO-fed serializer producing start, 5-8 data bits,
// optional parity and 1/1.5/2 stop bits, paced by a 16x baud enable.
module peripheral_uart_transmitter_wb
    import peripheral_wb_pkg::*;
#(
    parameter int FIFO_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_POINTER_W = 4,
    parameter int FIFO_COUNTER_W = 5
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic [7:0]                lcr,
    input  logic                      tf_push,
    input  logic [7:0]                wb_dat_i,
    input  logic                      enable,
    input  logic                      tx_reset,
    output logic                      stx_pad_o,
    output logic [2:0]                tstate,
    output logic [FIFO_COUNTER_W-1:0] tf_count
);

    // tf_push is a one-cycle write strobe with no back-pressure: a write
    // while the FIFO is full is silently dropped, so software polls tf_count.

    tx_state_e             state_q, state_d;
    logic [4:0]            tick_q, tick_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [FIFO_WIDTH-1:0] shift_q, shift_d;
    logic                  line_q, line_d;
    logic                  par_q, par_d;
    logic                  stx_q, stx_d;

    logic                      tf_pop;
    logic [FIFO_WIDTH-1:0]     tf_dout;
    logic [FIFO_COUNTER_W-1:0] tf_count_w;
    logic                      bit_done;
    logic                      lcr_unused;

    assign lcr_unused = lcr[7];

    peripheral_uart_tfifo_wb #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (FIFO_POINTER_W),
        .CNT_W (FIFO_COUNTER_W)
    ) u_tfifo (
        .clk      (clk),
        .rst      (wb_rst_i),
        .push     (tf_push),
        .pop      (tf_pop),
        .flush    (tx_reset),
        .data_in  (wb_dat_i),
        .data_out (tf_dout),
        .count    (tf_count_w)
    );

    assign bit_done = enable && (tick_q == '0);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        line_d    = line_q;
        par_d     = par_q;
        tf_pop    = 1'b0;

        // The tick counter only moves on enable pulses and reloads on each new bit.
        if (enable && (tick_q != '0) && (state_q != S_IDLE) && (state_q != S_POP_BYTE)) begin
            tick_d = tick_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                line_d = 1'b1;
                if (enable && line_q && (tf_count_w != '0)) begin
                    state_d = S_POP_BYTE;
                end
            end
            S_POP_BYTE: begin
                // A flush between idle and here leaves nothing to send.
                if (tf_count_w == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tf_pop  = 1'b1;
                    shift_d = tf_dout;
                    par_d   = 1'b0;
                    tick_d  = BIT_TICKS_M1;
                    line_d  = 1'b0;
                    state_d = S_SEND_START;
                end
            end
            S_SEND_START: begin
                if (bit_done) begin
                    state_d   = S_SEND_BYTE;
                    tick_d    = BIT_TICKS_M1;
                    bit_cnt_d = data_bits_m1(lcr[LCR_BITS +: 2]);
                    line_d    = shift_q[0];
                    par_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end
            S_SEND_BYTE: begin
                if (bit_done) begin
                    if (bit_cnt_q != '0) begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        tick_d    = BIT_TICKS_M1;
                        line_d    = shift_q[0];
                        par_d     = par_q ^ shift_q[0];
                        shift_d   = shift_q >> 1;
                    end else if (lcr[LCR_PE]) begin
                        state_d = S_SEND_PARITY;
                        tick_d  = BIT_TICKS_M1;
                        line_d  = parity_bit(lcr[LCR_SP], lcr[LCR_EP], par_q);
                    end else begin
                        state_d = S_SEND_STOP;
                        tick_d  = stop_ticks_m1(lcr[LCR_SB], lcr[LCR_BITS +: 2]);
                        line_d  = 1'b1;
                    end
                end
            end
            S_SEND_PARITY: begin
                if (bit_done) begin
                    state_d = S_SEND_STOP;
                    tick_d  = stop_ticks_m1(lcr[LCR_SB], lcr[LCR_BITS +: 2]);
                    line_d  = 1'b1;
                end
            end
            S_SEND_STOP: begin
                // Chain straight into the next character when one is waiting.
                if (bit_done) begin
                    line_d  = 1'b1;
                    state_d = (tf_count_w != '0) ? S_POP_BYTE : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                line_d  = 1'b1;
            end
        endcase

        stx_d = lcr[LCR_BC] ? 1'b0 : line_d;
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            line_q    <= 1'b1;
            par_q     <= 1'b0;
            stx_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            line_q    <= line_d;
            par_q     <= par_d;
            stx_q     <= stx_d;
        end
    end

    assign stx_pad_o = stx_q;
    assign tstate    = state_q;
    assign tf_count  = tf_count_w;

endmodule
